mem_dispatcher__write: RTL and testbench

Write-side companion of the line-buffer read dispatcher: on a one-shot start it streams a fixed number of words out of a synchronous-read line buffer and into one MCB user port, issuing DDR2 write commands in bursts of up to FIFO_LENGTH words. It sits in the `c3_clk0` domain between a line buffer filled by application logic and a DDR2 MCB port that is otherwise unused. It lets processed lines, such as segmentation masks, be stored back to external RAM.

---
 rtl/mem_dispatcher_pkg.sv | 25 ++
 rtl/mem_dispatcher__write.sv | 149 ++++++++++++++
 tb/tb_mem_dispatcher__write.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dispatcher_pkg.sv
// Shared definitions for the MCB line-buffer dispatchers (read and write side).
// The DRAIN state exists only when MEM_DISP_WR_DRAIN_WAIT_EN is defined.
package mem_dispatcher_pkg;

  typedef enum logic [2:0] {
    MCB_INSTR_WR = 3'b000,
    MCB_INSTR_RD = 3'b001
  } mcb_instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CALIB,
    ST_FILL,
    ST_CMD,
    ST_NEXT
`ifdef MEM_DISP_WR_DRAIN_WAIT_EN
    , ST_DRAIN
`endif
  } disp_state_t;

  function automatic int bytes_per_word(input bit port_64_bits);
    return port_64_bits ? 8 : 4;
  endfunction

endpackage

// File: rtl/mem_dispatcher__write.sv
// Streams WORDS_TO_WRITE line-buffer words into an MCB write port, one write command per burst.
// Define MEM_DISP_WR_DRAIN_WAIT_EN to keep busy high until the MCB write FIFO reports empty.
module mem_dispatcher__write
  import mem_dispatcher_pkg::*;
#(
  parameter int FIFO_LENGTH    = 64,
  parameter int WORDS_TO_WRITE = 640,
  parameter int BUFF_ADDR_BITS = 10,
  parameter int PORT_64_BITS   = 0,
  localparam int DW = (PORT_64_BITS != 0) ? 64 : 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      os_start,
  input  logic [29:0]               init_mem_addr,
  output logic                      busy_write_unit,
  output logic [BUFF_ADDR_BITS-1:0] data_in__addr,
  input  logic [DW-1:0]             data_in,
  input  logic                      mem_calib_done,
  output logic                      port_cmd_en,
  output logic [2:0]                port_cmd_instr,
  output logic [5:0]                port_cmd_bl,
  output logic [29:0]               port_cmd_byte_addr,
  output logic                      port_wr_en,
  output logic [DW-1:0]             port_wr_data,
  output logic [DW/8-1:0]           port_wr_mask,
  input  logic                      port_wr_full,
  input  logic                      port_wr_empty
);

  localparam int CNT_W = $clog2(WORDS_TO_WRITE + 1);
  localparam logic [29:0] BPW = 30'(bytes_per_word(PORT_64_BITS != 0));

  disp_state_t      state, state_next;
  logic [CNT_W-1:0] word_cnt;
  logic [6:0]       burst_cnt;
  logic [6:0]       burst_len;
  logic [29:0]      cur_addr;
  logic             data_valid;
  logic             push;
  logic             burst_done;
  logic             all_done;

  function automatic logic [6:0] burst_for(input logic [CNT_W-1:0] done_words);
    int remaining;
    remaining = WORDS_TO_WRITE - int'(done_words);
    return (remaining > FIFO_LENGTH) ? 7'(FIFO_LENGTH) : 7'(remaining);
  endfunction

  // data_valid marks that data_in holds buffer[word_cnt]; it drops whenever FILL is left
  assign push       = (state == ST_FILL) && data_valid && !port_wr_full;
  assign burst_done = push && (burst_cnt == burst_len - 7'd1);
  assign all_done   = (word_cnt == CNT_W'(WORDS_TO_WRITE));
  assign port_wr_mask = '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next         = state;
    busy_write_unit    = 1'b1;
    port_cmd_en        = 1'b0;
    port_cmd_instr     = 3'b000;
    port_cmd_bl        = '0;
    port_cmd_byte_addr = '0;
    port_wr_en         = push;
    port_wr_data       = push ? data_in : '0;
    data_in__addr      = '0;
    case (state)
      ST_IDLE: begin
        busy_write_unit = 1'b0;
        if (os_start) state_next = mem_calib_done ? ST_FILL : ST_WAIT_CALIB;
      end
      ST_WAIT_CALIB: begin
        if (mem_calib_done) state_next = ST_FILL;
      end
      ST_FILL: begin
        // Address only moves past a word once it is accepted, so a stall keeps data_in stable
        data_in__addr = BUFF_ADDR_BITS'(word_cnt + CNT_W'(push));
        if (burst_done) state_next = ST_CMD;
      end
      ST_CMD: begin
        port_cmd_en        = 1'b1;
        port_cmd_instr     = MCB_INSTR_WR;
        port_cmd_bl        = 6'(burst_len - 7'd1);
        port_cmd_byte_addr = cur_addr;
        state_next         = ST_NEXT;
      end
      ST_NEXT: begin
`ifdef MEM_DISP_WR_DRAIN_WAIT_EN
        state_next = all_done ? ST_DRAIN : ST_FILL;
`else
        state_next = all_done ? ST_IDLE : ST_FILL;
`endif
      end
`ifdef MEM_DISP_WR_DRAIN_WAIT_EN
      ST_DRAIN: begin
        if (port_wr_empty) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt   <= '0;
      burst_cnt  <= '0;
      burst_len  <= '0;
      cur_addr   <= '0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (os_start) begin
            cur_addr   <= init_mem_addr;
            word_cnt   <= '0;
            burst_cnt  <= '0;
            burst_len  <= burst_for('0);
            data_valid <= 1'b0;
          end
        end
        ST_FILL: begin
          data_valid <= !burst_done;
          if (push) begin
            word_cnt  <= word_cnt + CNT_W'(1);
            burst_cnt <= burst_cnt + 7'd1;
          end
        end
        ST_NEXT: begin
          cur_addr  <= cur_addr + ({23'd0, burst_len} * BPW);
          burst_cnt <= '0;
          burst_len <= burst_for(word_cnt);
        end
        default: begin
          data_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef MEM_DISP_WR_DRAIN_WAIT_EN
  logic unused_wr_empty;
  assign unused_wr_empty = port_wr_empty;
`endif

endmodule

// File: tb/tb_mem_dispatcher__write.sv
// Self-checking bench for mem_dispatcher__write: random buffer contents, bases and FIFO stalls
// compared against a burst/address model of the transfer.
module tb_mem_dispatcher__write;

  localparam int FIFO_LENGTH = 64;
  localparam int WORDS       = 100;
  localparam int ABITS       = 7;
  localparam int DW          = 32;
  localparam int NB          = (WORDS + FIFO_LENGTH - 1) / FIFO_LENGTH;
  localparam int BUDGET      = 2000;
`ifdef MEM_DISP_WR_DRAIN_WAIT_EN
  localparam int EXP_BUSY = WORDS + 3 * NB + 1;
`else
  localparam int EXP_BUSY = WORDS + 3 * NB;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             os_start = 1'b0;
  logic [29:0]      init_mem_addr = '0;
  logic             busy_write_unit;
  logic [ABITS-1:0] data_in__addr;
  logic [DW-1:0]    data_in;
  logic             mem_calib_done = 1'b1;
  logic             port_cmd_en;
  logic [2:0]       port_cmd_instr;
  logic [5:0]       port_cmd_bl;
  logic [29:0]      port_cmd_byte_addr;
  logic             port_wr_en;
  logic [DW-1:0]    port_wr_data;
  logic [DW/8-1:0]  port_wr_mask;
  logic             port_wr_full = 1'b0;
  logic             port_wr_empty = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] buffer [2**ABITS];

  mem_dispatcher__write #(
    .FIFO_LENGTH(FIFO_LENGTH), .WORDS_TO_WRITE(WORDS),
    .BUFF_ADDR_BITS(ABITS), .PORT_64_BITS(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .os_start(os_start), .init_mem_addr(init_mem_addr),
    .busy_write_unit(busy_write_unit), .data_in__addr(data_in__addr), .data_in(data_in),
    .mem_calib_done(mem_calib_done), .port_cmd_en(port_cmd_en), .port_cmd_instr(port_cmd_instr),
    .port_cmd_bl(port_cmd_bl), .port_cmd_byte_addr(port_cmd_byte_addr), .port_wr_en(port_wr_en),
    .port_wr_data(port_wr_data), .port_wr_mask(port_wr_mask), .port_wr_full(port_wr_full),
    .port_wr_empty(port_wr_empty)
  );

  always #5 clk = ~clk;

  // Synchronous-read line buffer
  always @(posedge clk) data_in <= buffer[data_in__addr];

  // Monitor: records MCB traffic mid-cycle, away from the active edge
  logic [DW-1:0] pushed_q[$];
  logic [29:0]   cmd_addr_q[$];
  logic [5:0]    cmd_bl_q[$];
  int            cmd_words_q[$];
  int bad_full_push, bad_mask, bad_instr, bad_cmd_gap;
  int cyc, last_push_cyc;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset_n) begin
      if (port_wr_en) begin
        if (port_wr_full) bad_full_push++;
        pushed_q.push_back(port_wr_data);
        last_push_cyc = cyc;
      end
      if (port_wr_mask != '0) bad_mask++;
      if (port_cmd_en) begin
        if (port_cmd_instr != 3'b000) bad_instr++;
        if (cyc != last_push_cyc + 1) bad_cmd_gap++;
        cmd_addr_q.push_back(port_cmd_byte_addr);
        cmd_bl_q.push_back(port_cmd_bl);
        cmd_words_q.push_back(pushed_q.size());
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({busy_write_unit, port_cmd_en, port_cmd_instr, port_cmd_bl, port_cmd_byte_addr,
                 port_wr_en, port_wr_data, port_wr_mask, data_in__addr});
  endfunction

  task automatic clear_monitor();
    pushed_q.delete();
    cmd_addr_q.delete();
    cmd_bl_q.delete();
    cmd_words_q.delete();
    bad_full_push = 0;
    bad_mask = 0;
    bad_instr = 0;
    bad_cmd_gap = 0;
  endtask

  task automatic fill_buffer();
    for (int i = 0; i < 2**ABITS; i++) buffer[i] = $urandom;
  endtask

  task automatic pulse_start(input logic [29:0] base);
    @(posedge clk); #1;
    init_mem_addr = base;
    os_start = 1'b1;
    @(posedge clk); #1;
    os_start = 1'b0;
    init_mem_addr = 30'($urandom);
  endtask

  task automatic wait_idle(input bit rnd_full, input string name, output int busy_cycles);
    bit done;
    done = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < BUDGET && !done; i++) begin
      if (rnd_full) port_wr_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (!busy_write_unit) done = 1'b1;
      else begin
        busy_cycles++;
        @(posedge clk); #1;
      end
    end
    port_wr_full = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL %s_timeout busy=%0b after %0d cycles, required 0", name, busy_write_unit, BUDGET);
    end
  endtask

  // Compares captured traffic with the expected bursts: base + k*FIFO_LENGTH*4, len min(FIFO, rest)
  task automatic score_transfer(input logic [29:0] base, input string name);
    int first_bad;
    checks++;
    if (cmd_addr_q.size() != NB) begin
      failures++;
      $display("[TB] FAIL %s_cmd_count got=%0d exp=%0d", name, cmd_addr_q.size(), NB);
    end
    for (int k = 0; k < NB && k < cmd_addr_q.size(); k++) begin
      logic [29:0] exp_addr;
      int exp_len;
      exp_addr = base + 30'(k * FIFO_LENGTH * (DW / 8));
      exp_len  = (WORDS - k * FIFO_LENGTH > FIFO_LENGTH) ? FIFO_LENGTH : WORDS - k * FIFO_LENGTH;
      checks++;
      if (cmd_addr_q[k] !== exp_addr) begin
        failures++;
        $display("[TB] FAIL %s_cmd%0d_addr got=%h exp=%h", name, k, cmd_addr_q[k], exp_addr);
      end
      checks++;
      if (int'(cmd_bl_q[k]) != exp_len - 1) begin
        failures++;
        $display("[TB] FAIL %s_cmd%0d_bl got=%0d exp=%0d", name, k, cmd_bl_q[k], exp_len - 1);
      end
      checks++;
      if (cmd_words_q[k] != k * FIFO_LENGTH + exp_len) begin
        failures++;
        $display("[TB] FAIL %s_cmd%0d_words_before got=%0d exp=%0d", name, k, cmd_words_q[k],
                 k * FIFO_LENGTH + exp_len);
      end
    end
    checks++;
    if (pushed_q.size() != WORDS) begin
      failures++;
      $display("[TB] FAIL %s_push_count got=%0d exp=%0d", name, pushed_q.size(), WORDS);
    end
    first_bad = -1;
    for (int i = 0; i < pushed_q.size() && i < WORDS; i++)
      if (first_bad < 0 && pushed_q[i] !== buffer[i]) first_bad = i;
    checks++;
    if (first_bad >= 0) begin
      failures++;
      $display("[TB] FAIL %s_data word%0d got=%h exp=%h", name, first_bad, pushed_q[first_bad], buffer[first_bad]);
    end
    checks++;
    if (bad_full_push != 0 || bad_mask != 0 || bad_instr != 0) begin
      failures++;
      $display("[TB] FAIL %s_protocol push_while_full=%0d mask_nonzero=%0d bad_instr=%0d exp all 0",
               name, bad_full_push, bad_mask, bad_instr);
    end
    checks++;
    if (bad_cmd_gap != 0) begin
      failures++;
      $display("[TB] FAIL %s_cmd_gap cmds_not_after_last_push=%0d exp=0", name, bad_cmd_gap);
    end
  endtask

  task automatic wait_final_cmd(input string name);
    for (int i = 0; i < BUDGET && cmd_addr_q.size() < NB; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (cmd_addr_q.size() < NB) begin
      failures++;
      $display("[TB] FAIL %s_final_cmd_timeout got=%0d cmds exp=%0d", name, cmd_addr_q.size(), NB);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", all_outs());
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_start_timing();
    logic [29:0] base;
    int bc;
    base = 30'h1000;
    clear_monitor();
    fill_buffer();
    pulse_start(base);
    @(negedge clk);
    checks++;
    if (busy_write_unit !== 1'b1 || data_in__addr !== '0 || port_wr_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_T1 busy=%0b addr=%0d wr_en=%0b exp busy=1 addr=0 wr_en=0",
               busy_write_unit, data_in__addr, port_wr_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (port_wr_en !== 1'b1 || port_wr_data !== buffer[0]) begin
      failures++;
      $display("[TB] FAIL start_T2 wr_en=%0b data=%h exp wr_en=1 data=%h", port_wr_en, port_wr_data, buffer[0]);
    end
    @(posedge clk); #1;
    wait_idle(1'b0, "start_timing", bc);
    checks++;
    if (bc + 2 != EXP_BUSY) begin
      failures++;
      $display("[TB] FAIL busy_length got=%0d exp=%0d", bc + 2, EXP_BUSY);
    end
    score_transfer(base, "start_timing");
  endtask

  task automatic test_stall();
    logic [29:0]      base;
    logic [ABITS-1:0] held_addr;
    int bad_push, bad_addr, n_at_stall, bc;
    base = 30'($urandom);
    clear_monitor();
    fill_buffer();
    pulse_start(base);
    for (int i = 0; i < BUDGET && pushed_q.size() < 20; i++) begin
      @(posedge clk); #1;
    end
    n_at_stall = pushed_q.size();
    port_wr_full = 1'b1;
    bad_push = 0;
    bad_addr = 0;
    held_addr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) held_addr = data_in__addr;
      else if (data_in__addr !== held_addr) bad_addr++;
      if (port_wr_en) bad_push++;
      @(posedge clk); #1;
    end
    port_wr_full = 1'b0;
    checks++;
    if (bad_push != 0) begin
      failures++;
      $display("[TB] FAIL stall_push pushes_while_full=%0d exp=0", bad_push);
    end
    checks++;
    if (bad_addr != 0 || int'(held_addr) != n_at_stall) begin
      failures++;
      $display("[TB] FAIL stall_addr addr=%0d moved=%0d exp addr=%0d moved=0", held_addr, bad_addr, n_at_stall);
    end
    wait_idle(1'b1, "stall", bc);
    score_transfer(base, "stall");
  endtask

  task automatic test_calib_wait();
    logic [29:0] base;
    int busy_bad, activity, bc;
    base = 30'($urandom);
    clear_monitor();
    fill_buffer();
    mem_calib_done = 1'b0;
    pulse_start(base);
    busy_bad = 0;
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_write_unit !== 1'b1) busy_bad++;
      if (port_wr_en || port_cmd_en) activity++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_bad != 0 || activity != 0) begin
      failures++;
      $display("[TB] FAIL calib_wait busy_low_cycles=%0d mcb_activity=%0d exp 0 and 0", busy_bad, activity);
    end
    mem_calib_done = 1'b1;
    wait_idle(1'b0, "calib_wait", bc);
    score_transfer(base, "calib_wait");
  endtask

  task automatic test_second_start();
    logic [29:0] base;
    int bc;
    base = 30'($urandom);
    clear_monitor();
    fill_buffer();
    pulse_start(base);
    repeat (30) @(posedge clk);
    #1;
    os_start = 1'b1;
    init_mem_addr = 30'($urandom);
    @(posedge clk); #1;
    os_start = 1'b0;
    wait_final_cmd("second_start");
    os_start = 1'b1;
    @(posedge clk); #1;
    os_start = 1'b0;
    wait_idle(1'b0, "second_start", bc);
    score_transfer(base, "second_start");
    repeat (10) @(negedge clk);
    checks++;
    if (busy_write_unit !== 1'b0 || cmd_addr_q.size() != NB) begin
      failures++;
      $display("[TB] FAIL ignored_start busy=%0b cmds=%0d exp busy=0 cmds=%0d", busy_write_unit,
               cmd_addr_q.size(), NB);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] base;
    int bc;
    clear_monitor();
    fill_buffer();
    pulse_start(30'($urandom));
    for (int i = 0; i < BUDGET && pushed_q.size() < 10; i++) begin
      @(posedge clk); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs got=%h exp=0", all_outs());
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_monitor();
    base = 30'($urandom);
    pulse_start(base);
    wait_idle(1'b0, "after_reset", bc);
    score_transfer(base, "after_reset");
  endtask

  task automatic test_random_stream();
    logic [29:0] base;
    int bc;
    for (int r = 0; r < 3; r++) begin
      base = (r == 0) ? 30'h3FFF_FFC0 : 30'($urandom);
      clear_monitor();
      fill_buffer();
      pulse_start(base);
      wait_idle(1'b1, "random_stream", bc);
      score_transfer(base, "random_stream");
    end
  endtask

`ifdef MEM_DISP_WR_DRAIN_WAIT_EN
  task automatic test_drain();
    logic [29:0] base;
    int busy_bad, bc;
    base = 30'($urandom);
    clear_monitor();
    fill_buffer();
    port_wr_empty = 1'b0;
    pulse_start(base);
    wait_final_cmd("drain");
    busy_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_write_unit !== 1'b1) busy_bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("[TB] FAIL drain_hold busy_low_cycles=%0d exp=0", busy_bad);
    end
    port_wr_empty = 1'b1;
    wait_idle(1'b0, "drain", bc);
    checks++;
    if (bc != 1) begin
      failures++;
      $display("[TB] FAIL drain_release busy_cycles=%0d exp=1", bc);
    end
    score_transfer(base, "drain");
  endtask
`endif

  initial begin
    test_reset();
    test_start_timing();
    test_stall();
    test_calib_wait();
    test_second_start();
    test_reset_mid();
    test_random_stream();
`ifdef MEM_DISP_WR_DRAIN_WAIT_EN
    test_drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
